serial_operand_tx: RTL
======================

# serial_operand_tx

Parallel-to-serial operand transmitter: accepts two WIDTH-bit operands through a valid/ready handshake and drives them LSB-first, one bit pair per clock, on the `a`/`b` serial lines. It frames each operand pair with a `start` pulse on the first bit and a `last` pulse on the final bit. It is the transmit end of the serial-adder interface and sits between a parallel operand source and the serial adder.

## Interface
- WIDTH, 6, operand width in bits and frame length in clocks; legal range 1..32.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on op_a/op_b is valid.
- in_ready  output  1  transmitter can accept an operand pair this cycle.
- op_a  input  WIDTH  operand A, parallel.
- op_b  input  WIDTH  operand B, parallel.
- a  output  1  serial bit of operand A, LSB first.
- b  output  1  serial bit of operand B, LSB first.
- start  output  1  high with bit 0 of a frame.
- last  output  1  high with bit WIDTH-1 of a frame.
- busy  output  1  a frame bit is being driven this cycle.

## Operation
- State machine: IDLE and SHIFT. Internal state is two WIDTH-bit shift registers (sh_a, sh_b) and a bit counter cnt with range 0..WIDTH-1.
- Accept occurs when in_valid & in_ready at a rising edge. On accept:
  - op_a and op_b load into sh_a and sh_b.
  - cnt clears to 0.
  - State moves to SHIFT.
- In SHIFT:
  - a = sh_a[0], b = sh_b[0].
  - busy = 1.
  - start = (cnt == 0).
  - last = (cnt == WIDTH-1).
  - Each clock, both shift registers shift right by one and cnt increments.
- At cnt == WIDTH-1, the frame ends. The next state is IDLE, unless the back-to-back option (see Configuration) accepts a new pair in the same cycle.
- In IDLE, a, b, start, last and busy are all 0.
- in_valid is ignored whenever in_ready is 0. Operands are sampled only at accept; later changes on op_a/op_b do not affect the frame in flight.
- WIDTH == 1: start and last are both high in the single frame cycle.
- Reset, including mid-frame:
  - The frame is aborted and state returns to IDLE.
  - a, b, start, last and busy are 0 from the first cycle after the reset edge.
  - No partial frame resumes.
  - in_ready = 1 once rst deasserts.

## Timing
- Reset values: a=0, b=0, start=0, last=0, busy=0, in_ready=1 (sampled with rst low).
- in_ready is combinational from state. It does not depend combinationally on in_valid.
- Latency: accept at edge T puts bit 0 on a/b with start=1 in cycle T+1. Bit k appears in cycle T+1+k, and last=1 in cycle T+WIDTH.
- a, b, start, last and busy are registered outputs with no combinational path from any input.
- Frame bits are stable for the full cycle, so the receiver samples them on the following rising edge.

## Configuration
- SERIAL_TX_B2B_EN, when defined:
  - in_ready = IDLE | (SHIFT & cnt == WIDTH-1).
  - An accept during the last bit starts the next frame with no gap: start is high the cycle immediately after last, and busy stays 1 throughout.
- SERIAL_TX_B2B_EN, when not defined:
  - in_ready = IDLE only.
  - Frames are separated by at least one idle cycle (busy=0, start=0) after each last.

## Test plan
- Reset: hold rst for 2 cycles, then release -> a=b=start=last=busy=0 and in_ready=1.
- Single frame, WIDTH=6: op_a=6'b101101, op_b=6'b000111 accepted at T.
  - a = 1,0,1,1,0,1 in cycles T+1..T+6.
  - b = 1,1,1,0,0,0 in the same cycles.
  - start=1 only at T+1, last=1 only at T+6, busy=1 for T+1..T+6, IDLE at T+7.
- Back-to-back: in_valid held high with pairs (45,7) then (63,63).
  - Without SERIAL_TX_B2B_EN: second start at T+8.
  - With SERIAL_TX_B2B_EN: second start at T+7, and the second frame shows a=b=1 for 6 cycles.
- Hold-off: change op_a to 0 and pulse in_valid during cycle T+3 of a frame -> the frame bits are unchanged and no accept occurs until in_ready=1.
- Mid-frame reset: assert rst at T+3 -> outputs are 0 at T+4. After release, a new accept at edge U puts start=1 with bit 0 in cycle U+1.
- WIDTH=1 build: accept op_a=1, op_b=0 -> one cycle with a=1, b=0, start=1, last=1.

Source files
------------

// File: rtl/serial_operand_tx.sv
// serial_operand_tx
// Parallel-to-serial operand transmitter. Accepts an operand pair (op_a, op_b)
// over a valid/ready handshake and drives it LSB-first, one bit pair per clock,
// on a/b. start marks bit 0 of a frame and last marks bit WIDTH-1.
//
// Parameters:
//   WIDTH     operand width and frame length in clocks (1..32)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_valid  operand pair on op_a/op_b is valid
//   in_ready  transmitter can accept a pair this cycle (from state only)
//   op_a      operand A, parallel
//   op_b      operand B, parallel
//   a, b      serial operand bits, LSB first
//   start     high with bit 0 of a frame
//   last      high with bit WIDTH-1 of a frame
//   busy      a frame bit is being driven this cycle
//
// Optional feature macro: SERIAL_TX_B2B_EN
//   When defined, a new pair can be accepted during the last bit of a frame so
//   that frames follow each other with no idle gap. When undefined, a pair is
//   accepted only in IDLE and frames are separated by at least one idle cycle.
module serial_operand_tx #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             a,
  output logic             b,
  output logic             start,
  output logic             last,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             at_last;

  // Control: handshake and next state. in_ready depends only on registered
  // state, never on in_valid.
  always_comb begin
    state_nxt = state;
    at_last   = (state == SHIFT) && (cnt == CNT_LAST);
`ifdef SERIAL_TX_B2B_EN
    in_ready  = (state == IDLE) || at_last;
`else
    in_ready  = (state == IDLE);
`endif
    accept    = in_valid && in_ready;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (at_last && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: gated by the registered state, so everything seen on the serial
  // side comes straight from flops and is stable for the whole cycle.
  always_comb begin
    busy  = (state == SHIFT);
    a     = busy && sh_a[0];
    b     = busy && sh_b[0];
    start = busy && (cnt == '0);
    last  = at_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: operands are captured only on accept, so later changes on
  // op_a/op_b cannot disturb a frame in flight. No reset needed here because
  // every output is gated by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_a <= op_a;
      sh_b <= op_b;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule
